// File: rtl/axil_sram_banked.sv
// AXI4-Lite slave over an internal word array with independent read/write FSMs,
// fixed programmable latencies and SLVERR range checking; all outputs registered or state-decoded.
module axil_sram_banked #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    DEPTH         = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h8000_0000,
  parameter int                    READ_LATENCY  = 10,
  parameter int                    WRITE_LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int STRB  = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(STRB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] RLAT = 8'(READ_LATENCY);
  localparam logic [7:0] WLAT = 8'(WRITE_LATENCY);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------- read channel ----------------
  rd_state_t             r_rd_state;
  rd_state_t             w_rd_next;
  logic [7:0]            r_rd_cnt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_rd_fire;
  logic [ADDR_WIDTH-1:0] w_rd_off;
  logic                  w_rd_oor;
  logic [IDX_W-1:0]      w_rd_idx;

  assign w_rd_off = r_araddr - BASE_ADDR;
  assign w_rd_oor = (r_araddr < BASE_ADDR) || ((w_rd_off >> LSB) >= ADDR_WIDTH'(DEPTH));
  assign w_rd_idx = w_rd_off[LSB +: IDX_W];

  always_comb begin
    w_rd_next = r_rd_state;
    w_rd_fire = 1'b0;
    unique case (r_rd_state)
      RD_IDLE: if (arvalid) w_rd_next = RD_WAIT;
      RD_WAIT: begin
        if (r_rd_cnt == RLAT) begin
          w_rd_next = RD_RESP;
          w_rd_fire = 1'b1;
        end
      end
      RD_RESP: if (rready) w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_state <= RD_IDLE;
      r_rd_cnt   <= '0;
      r_araddr   <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      r_rd_state <= w_rd_next;
      if (r_rd_state == RD_IDLE && arvalid) begin
        r_araddr <= araddr;
        r_rd_cnt <= '0;
      end else if (r_rd_state == RD_WAIT && !w_rd_fire) begin
        r_rd_cnt <= r_rd_cnt + 8'd1;
      end
      // Sampled with a non-blocking read, so a same-edge commit is not visible here.
      if (w_rd_fire) begin
        r_rdata <= w_rd_oor ? '0 : r_mem[w_rd_idx];
        r_rresp <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign arready = (r_rd_state == RD_IDLE);
  assign rvalid  = (r_rd_state == RD_RESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  // ---------------- write channel ----------------
  wr_state_t             r_wr_state;
  wr_state_t             w_wr_next;
  logic [7:0]            r_wr_cnt;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB-1:0]       r_wstrb;
  logic [1:0]            r_bresp;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_both;
  logic                  w_wr_commit;
  logic [ADDR_WIDTH-1:0] w_wr_off;
  logic                  w_wr_oor;
  logic [IDX_W-1:0]      w_wr_idx;

  assign w_aw_hs  = (r_wr_state == WR_IDLE) && !r_aw_held && awvalid;
  assign w_w_hs   = (r_wr_state == WR_IDLE) && !r_w_held && wvalid;
  assign w_both   = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_off = r_awaddr - BASE_ADDR;
  assign w_wr_oor = (r_awaddr < BASE_ADDR) || ((w_wr_off >> LSB) >= ADDR_WIDTH'(DEPTH));
  assign w_wr_idx = w_wr_off[LSB +: IDX_W];

  always_comb begin
    w_wr_next   = r_wr_state;
    w_wr_commit = 1'b0;
    unique case (r_wr_state)
      WR_IDLE: if (w_both) w_wr_next = WR_WAIT;
      WR_WAIT: begin
        if (r_wr_cnt == WLAT) begin
          w_wr_next   = WR_RESP;
          w_wr_commit = 1'b1;
        end
      end
      WR_RESP: if (bready) w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_state <= WR_IDLE;
      r_wr_cnt   <= '0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_aw_hs) begin
        r_awaddr  <= awaddr;
        r_aw_held <= 1'b1;
      end
      if (w_w_hs) begin
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
        r_w_held <= 1'b1;
      end
      if (r_wr_state == WR_IDLE && w_both) begin
        r_wr_cnt <= '0;
      end else if (r_wr_state == WR_WAIT && !w_wr_commit) begin
        r_wr_cnt <= r_wr_cnt + 8'd1;
      end
      if (w_wr_commit) begin
        r_bresp <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
      end
      if (r_wr_state == WR_RESP && bready) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
    end
  end

  // Array has no reset; commit only fires from WAIT, so a reset drops uncommitted writes.
  always_ff @(posedge clk) begin
    if (w_wr_commit && !w_wr_oor) begin
      for (int i = 0; i < STRB; i++) begin
        if (r_wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign awready = (r_wr_state == WR_IDLE) && !r_aw_held;
  assign wready  = (r_wr_state == WR_IDLE) && !r_w_held;
  assign bvalid  = (r_wr_state == WR_RESP);
  assign bresp   = r_bresp;

endmodule
